sbox_arbiter192: RTL and testbench
==================================

# sbox_arbiter192

Shares the single byte-wide S-box of the low-area AES-192 core between two requesters: the key scheduler (port 0) and the byte-serial round datapath (port 1). It owns the S-box lookup register, grants the S-box to one requester at a time with burst locking, and returns each result one cycle after acceptance. The S-box therefore behaves as a one-cycle-latency resource. The arbiter sits between both requesters and the S-box table inside the AES-192 top level.

## Interface
- MAX_BURST, 8, maximum accepted lookups per grant while the other port is requesting; legal range 1..15.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_i  in  1  key scheduler requests the S-box; held for the whole burst.
- data0_i  in  8  key scheduler lookup byte.
- dec0_i  in  1  key scheduler: 1 selects the inverse S-box.
- req1_i, data1_i, dec1_i  in  1/8/1  the same three signals for the datapath port.
- gnt0_o, gnt1_o  out  1 each  registered ownership of the S-box.
- rvalid0_o, rvalid1_o  out  1 each  result valid for that port.
- rdata_o  out  8  registered S-box result, shared by both ports.

## Operation
- FSM states: IDLE, OWN0, OWN1. gnt0_o=(state==OWN0), gnt1_o=(state==OWN1).
- A lookup is accepted in any cycle with reqX_i & gntX_o. On acceptance the arbiter registers rdata_o <= S(dataX_i), or S⁻¹ if decX_i=1. rvalidX_o=1 in the next cycle; otherwise rvalidX_o=0 and rdata_o holds its value.
- IDLE: no request → stay in IDLE. One request → go to OWN of that port. Both requesting → the winner comes from the arbitration policy (see Configuration).
- OWNx with reqx_i=0 (release): if the other port is requesting, go directly to its OWN state; otherwise go to IDLE.
- OWNx with reqx_i=1: a burst counter (4 bits) increments on each acceptance.
  - If the counter has reached MAX_BURST and the other port is requesting, go to the other OWN state. The lookup in that cycle is not accepted.
  - Otherwise stay in OWNx. With no competitor the burst is unbounded and the counter saturates.
- The burst counter clears on every state change.
- last_owner register: updated on every entry into OWN0 or OWN1.
- A request on a port without grant is simply held. Requesters must keep reqX_i, dataX_i and decX_i stable until granted.
- Simultaneous events:
  - The owner releases in the same cycle the other port raises its request → handover happens with no IDLE cycle.
  - Both ports raise their requests in the same IDLE cycle → policy decides.
- The dataX_i value in the release cycle is ignored.

## Timing
- Reset values: state=IDLE, gnt0_o=gnt1_o=0, rvalid0_o=rvalid1_o=0, rdata_o=8'h00, burst counter=0, last_owner=1 (so port 0 wins first contention).
- Request-to-grant latency from IDLE: 1 cycle.
- Acceptance-to-data latency: 1 cycle. While granted the port gets one lookup per cycle, back-to-back.
- Handover on release or burst limit: the new owner's gnt rises the cycle after the decision. Any cycle has at most one gnt and at most one rvalid high.
- Reset asserted mid-burst: all outputs return to reset values immediately. An in-flight result is dropped and no rvalid is produced.

## Configuration
- SBOX_ARB_ROUND_ROBIN_EN defined: on contention from IDLE, and on release with both pending, the port that is not last_owner wins.
- Undefined: port 0 (key scheduler) always wins from IDLE. last_owner is not implemented. The MAX_BURST forced handover still applies, so port 1 is never starved indefinitely.

## Structure
- Shared package aes192_pkg holds:
  - state encoding constants (IDLE=0, OWN0=1, OWN1=2);
  - the burst counter width;
  - the AES-192 common constants already used by the key scheduler.
- One sub-module, sbox_lut: combinational 8-bit forward/inverse S-box table with inputs byte and decrypt. The arbiter muxes the granted port's data and decrypt flag into sbox_lut and registers the output.

## Test plan
- Reset, then req0_i=1, data0_i=8'h00, dec0_i=0 → gnt0_o=1 in cycle 1; rvalid0_o=1 and rdata_o=8'h63 in cycle 2.
- Port 0 burst of 8'h01, 8'h53, then 8'h63 with dec0_i=1 → rdata_o returns 8'h7C, 8'hED, 8'h00 on consecutive cycles.
- req0_i and req1_i rise together from IDLE with SBOX_ARB_ROUND_ROBIN_EN defined → port 0 wins first. After port 0 releases and the same contention is repeated, port 1 wins.
- MAX_BURST=4, port 1 owns and requests continuously, port 0 requests → exactly 4 rvalid1_o pulses, then gnt1_o falls and gnt0_o rises the next cycle.
- Port 0 releases in the same cycle port 1 raises req1_i → gnt1_o=1 in the next cycle with no IDLE cycle; gnt0_o and gnt1_o are never both 1.
- reset pulsed while port 1 has an accepted lookup in flight → rvalid1_o stays 0, gnt1_o and rdata_o clear to 0 immediately, and state is IDLE after reset is released.

Source files
------------

// File: rtl/aes192_pkg.sv
// aes192_pkg
// Shared definitions for the low-area AES-192 core: arbiter state encoding,
// burst counter width, AES-192 round/key constants and GF(2^8) arithmetic.
// No ports.
package aes192_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int BURST_W = 4;

  localparam int AES192_NB = 4;
  localparam int AES192_NK = 6;
  localparam int AES192_NR = 12;

  localparam logic [7:0] SBOX_FWD_C = 8'h63;
  localparam logic [7:0] SBOX_INV_C = 8'h05;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/sbox_arbiter192_sbox_lut.sv
// sbox_lut
// Combinational AES forward/inverse S-box. Computed as GF(2^8) inversion
// plus affine transform rather than stored as two 256-entry tables.
// Ports:
//   i_byte    in  8  lookup byte
//   i_decrypt in  1  1 selects the inverse S-box
//   o_result  out 8  S(i_byte) or S^-1(i_byte)
module sbox_lut
  import aes192_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_decrypt,
  output logic [7:0] o_result
);

  // x^254 is the multiplicative inverse; 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    logic [7:0] e;
    r = 8'h01;
    b = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++)
      y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8]
           ^ x[(i + 7) % 8] ^ SBOX_FWD_C[i];
    return y;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++)
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ SBOX_INV_C[i];
    return y;
  endfunction

  always_comb begin
    o_result = 8'h00;
    if (i_decrypt) o_result = gf_inv(affine_inv(i_byte));
    else           o_result = affine_fwd(gf_inv(i_byte));
  end

endmodule

// File: rtl/sbox_arbiter192.sv
// sbox_arbiter192
// Shares the single S-box between the key scheduler (port 0) and the round
// datapath (port 1) with burst locking; results return one cycle after
// acceptance.
// Optional feature macro: SBOX_ARB_ROUND_ROBIN_EN -- contention from IDLE is
// won by the port that did not own the S-box last. Undefined: port 0 wins.
// Parameter: MAX_BURST (1..15) lookups per grant while the other port waits.
// Ports:
//   clk, reset              clock, async active-high reset
//   req0_i/data0_i/dec0_i   key scheduler request, byte, inverse select
//   req1_i/data1_i/dec1_i   datapath request, byte, inverse select
//   gnt0_o/gnt1_o           registered S-box ownership
//   rvalid0_o/rvalid1_o     result valid for that port
//   rdata_o                 shared registered S-box result
module sbox_arbiter192
  import aes192_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_i,
  input  logic [7:0] data0_i,
  input  logic       dec0_i,
  input  logic       req1_i,
  input  logic [7:0] data1_i,
  input  logic       dec1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       rvalid0_o,
  output logic       rvalid1_o,
  output logic [7:0] rdata_o
);

  arb_state_t           r_state;
  logic [BURST_W-1:0]   r_cnt;
  logic                 r_gnt0, r_gnt1;
  logic                 r_rvalid0, r_rvalid1;
  logic [7:0]           r_rdata;
`ifdef SBOX_ARB_ROUND_ROBIN_EN
  logic                 r_last_owner;
`endif

  arb_state_t           w_next;
  arb_state_t           w_idle_pick;
  logic                 w_acc0, w_acc1;
  logic                 w_limit;
  logic [7:0]           w_lut_in;
  logic                 w_lut_dec;
  logic [7:0]           w_lut_out;

`ifdef SBOX_ARB_ROUND_ROBIN_EN
  assign w_idle_pick = r_last_owner ? ST_OWN0 : ST_OWN1;
`else
  assign w_idle_pick = ST_OWN0;
`endif

  assign w_limit = (r_cnt >= BURST_W'(MAX_BURST));

  // On release the other port is the only candidate, so no policy is needed
  // there; a forced handover at the burst limit drops that cycle's lookup.
  always_comb begin
    w_next = r_state;
    w_acc0 = 1'b0;
    w_acc1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_i && req1_i) w_next = w_idle_pick;
        else if (req0_i)      w_next = ST_OWN0;
        else if (req1_i)      w_next = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req0_i)                w_next = req1_i ? ST_OWN1 : ST_IDLE;
        else if (w_limit && req1_i) w_next = ST_OWN1;
        else                        w_acc0 = 1'b1;
      end
      ST_OWN1: begin
        if (!req1_i)                w_next = req0_i ? ST_OWN0 : ST_IDLE;
        else if (w_limit && req0_i) w_next = ST_OWN0;
        else                        w_acc1 = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_lut_in  = (r_state == ST_OWN1) ? data1_i : data0_i;
  assign w_lut_dec = (r_state == ST_OWN1) ? dec1_i  : dec0_i;

  sbox_lut u_sbox_lut (
    .i_byte    (w_lut_in),
    .i_decrypt (w_lut_dec),
    .o_result  (w_lut_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= 8'h00;
`ifdef SBOX_ARB_ROUND_ROBIN_EN
      r_last_owner <= 1'b1;
`endif
    end else begin
      r_state   <= w_next;
      r_gnt0    <= (w_next == ST_OWN0);
      r_gnt1    <= (w_next == ST_OWN1);
      r_rvalid0 <= w_acc0;
      r_rvalid1 <= w_acc1;
      if (w_acc0 || w_acc1) r_rdata <= w_lut_out;
      // Saturates so an uncontested burst can run forever.
      if (w_next != r_state)
        r_cnt <= '0;
      else if ((w_acc0 || w_acc1) && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
`ifdef SBOX_ARB_ROUND_ROBIN_EN
      if (w_next != r_state) begin
        if (w_next == ST_OWN0) r_last_owner <= 1'b0;
        if (w_next == ST_OWN1) r_last_owner <= 1'b1;
      end
`endif
    end
  end

  assign gnt0_o    = r_gnt0;
  assign gnt1_o    = r_gnt1;
  assign rvalid0_o = r_rvalid0;
  assign rvalid1_o = r_rvalid1;
  assign rdata_o   = r_rdata;

endmodule

// File: tb/tb_sbox_arbiter192.sv
// Testbench for sbox_arbiter192 (MAX_BURST=4). Lookups expected to be
// accepted are pushed to a scoreboard; a monitor pops on every rvalid.
module tb_sbox_arbiter192;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, dec0, req1, dec1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  sbox_arbiter192 #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_i    (req0),
    .data0_i   (data0),
    .dec0_i    (dec0),
    .req1_i    (req1),
    .data1_i   (data1),
    .dec1_i    (dec1),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .rvalid0_o (rvalid0),
    .rvalid1_o (rvalid1),
    .rdata_o   (rdata)
  );

  typedef struct {logic port; logic [7:0] data;} sb_t;
  typedef struct {logic [7:0] din; logic dec; logic [7:0] exp;} vec_t;

  sb_t  sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rv1    = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: exclusivity and scoreboard compare, 1 ns after each edge.
  always @(posedge clk) begin
    sb_t e;
    #1;
    check8("one_gnt", {7'b0, gnt0 & gnt1}, 8'h00);
    check8("one_rvalid", {7'b0, rvalid0 & rvalid1}, 8'h00);
    if (rvalid1) n_rv1++;
    if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got rvalid with data %0h, expected no result", rdata);
      end else begin
        e = sb.pop_front();
        check8("rv_port", {7'b0, rvalid1}, {7'b0, e.port});
        check8("rdata", rdata, e.data);
      end
    end
  end

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 8'h63};
    vecs[1]  = '{8'h01, 1'b0, 8'h7c};
    vecs[2]  = '{8'h53, 1'b0, 8'hed};
    vecs[3]  = '{8'h63, 1'b1, 8'h00};
    vecs[4]  = '{8'hff, 1'b0, 8'h16};
    vecs[5]  = '{8'h10, 1'b0, 8'hca};
    vecs[6]  = '{8'hab, 1'b0, 8'h62};
    vecs[7]  = '{8'hed, 1'b1, 8'h53};
    vecs[8]  = '{8'h16, 1'b1, 8'hff};
    vecs[9]  = '{8'h00, 1'b1, 8'h52};
    vecs[10] = '{8'h1f, 1'b0, 8'hc0};
    vecs[11] = '{8'h7c, 1'b1, 8'h01};

    reset = 1'b1;
    req0 = 1'b0; data0 = 8'h00; dec0 = 1'b0;
    req1 = 1'b0; data1 = 8'h00; dec1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check8("rst_gnt0", {7'b0, gnt0}, 8'h00);
    check8("rst_gnt1", {7'b0, gnt1}, 8'h00);
    check8("rst_rvalid0", {7'b0, rvalid0}, 8'h00);
    check8("rst_rvalid1", {7'b0, rvalid1}, 8'h00);
    check8("rst_rdata", rdata, 8'h00);

    // Uncontested port-0 burst, longer than MAX_BURST.
    req0 = 1'b1; data0 = vecs[0].din; dec0 = vecs[0].dec;
    tick();
    check8("grant_latency", {7'b0, gnt0}, 8'h01);
    check8("no_early_rvalid", {7'b0, rvalid0}, 8'h00);
    for (int i = 0; i < 12; i++) begin
      data0 = vecs[i].din;
      dec0  = vecs[i].dec;
      sb.push_back('{1'b0, vecs[i].exp});
      tick();
      check8("burst_gnt0", {7'b0, gnt0}, 8'h01);
    end
    req0 = 1'b0;
    tick();
    check8("release_idle", {7'b0, gnt0}, 8'h00);
    tick();
    check8("sb_drained_a", 8'(sb.size()), 8'h00);

    // Contention from IDLE, twice, starting from reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; data0 = 8'h01; dec0 = 1'b0;
    req1 = 1'b1; data1 = 8'h02; dec1 = 1'b0;
    tick();
    check8("contend1_gnt0", {7'b0, gnt0}, 8'h01);
    check8("contend1_gnt1", {7'b0, gnt1}, 8'h00);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check8("contend1_idle", {6'b0, gnt1, gnt0}, 8'h00);
    req0 = 1'b1; req1 = 1'b1;
    tick();
`ifdef SBOX_ARB_ROUND_ROBIN_EN
    check8("contend2_gnt0", {7'b0, gnt0}, 8'h00);
    check8("contend2_gnt1", {7'b0, gnt1}, 8'h01);
`else
    check8("contend2_gnt0", {7'b0, gnt0}, 8'h01);
    check8("contend2_gnt1", {7'b0, gnt1}, 8'h00);
`endif
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check8("contend2_idle", {6'b0, gnt1, gnt0}, 8'h00);

    // Port 1 burst cut at MAX_BURST by a waiting port 0.
    req1 = 1'b1; data1 = vecs[0].din; dec1 = vecs[0].dec;
    tick();
    check8("own1_gnt1", {7'b0, gnt1}, 8'h01);
    req0 = 1'b1; data0 = 8'h01; dec0 = 1'b0;
    n_rv1 = 0;
    for (int j = 0; j < 4; j++) begin
      data1 = vecs[j + 1].din;
      dec1  = vecs[j + 1].dec;
      sb.push_back('{1'b1, vecs[j + 1].exp});
      tick();
    end
    data1 = vecs[5].din; dec1 = vecs[5].dec;
    tick();
    check8("limit_gnt1", {7'b0, gnt1}, 8'h00);
    check8("limit_gnt0", {7'b0, gnt0}, 8'h01);
    check8("limit_no_rv1", {7'b0, rvalid1}, 8'h00);
    sb.push_back('{1'b0, 8'h7c});
    tick();
    check8("limit_rv1_count", 8'(n_rv1), 8'd4);
    check8("limit_hold_gnt0", {7'b0, gnt0}, 8'h01);
    req0 = 1'b0;
    tick();
    check8("release_handover_gnt1", {7'b0, gnt1}, 8'h01);
    check8("release_handover_gnt0", {7'b0, gnt0}, 8'h00);
    req1 = 1'b0;
    tick();
    check8("idle_after_c", {6'b0, gnt1, gnt0}, 8'h00);

    // Release and raise in the same cycle: direct handover.
    req0 = 1'b1; data0 = 8'h53; dec0 = 1'b0;
    tick();
    sb.push_back('{1'b0, 8'hed});
    tick();
    req0 = 1'b0;
    req1 = 1'b1; data1 = 8'h10; dec1 = 1'b0;
    tick();
    check8("same_cycle_gnt1", {7'b0, gnt1}, 8'h01);
    check8("same_cycle_gnt0", {7'b0, gnt0}, 8'h00);
    sb.push_back('{1'b1, 8'hca});
    tick();
    check8("pre_reset_rdata", rdata, 8'hca);

    // Reset with the next port-1 lookup being presented.
    data1 = 8'hff;
    #2 reset = 1'b1;
    #1;
    check8("midrst_gnt1", {7'b0, gnt1}, 8'h00);
    check8("midrst_rvalid1", {7'b0, rvalid1}, 8'h00);
    check8("midrst_rdata", rdata, 8'h00);
    tick();
    check8("midrst_hold_rvalid1", {7'b0, rvalid1}, 8'h00);
    reset = 1'b0;
    req1 = 1'b0;
    check8("postrst_gnt", {6'b0, gnt1, gnt0}, 8'h00);
    tick();
    check8("postrst_idle", {6'b0, gnt1, gnt0}, 8'h00);
    check8("postrst_rvalid1", {7'b0, rvalid1}, 8'h00);
    tick();
    check8("sb_drained_end", 8'(sb.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
